// File: rtl/dft_result_reader.sv
// rtl/dft_result_reader.sv - result RAM readout streamer with 2-deep output FIFO and valid/ready backpressure
// Optional: DFT_READER_BITREV_EN selects bit-reversed RAM addressing for natural-order radix-2 FFT output.
module dft_result_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ce,
   input  logic [ADDR_W-1:0] sample_num,
   input  logic              calc_end,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [ADDR_W-1:0] m_index,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      DONE_ST = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [ADDR_W-1:0]   n_q;
   logic [ADDR_W-1:0]   rd_idx_q;
   logic                inflight_q;
   logic [ADDR_W-1:0]   infl_idx_q;
   logic [1:0]          cnt_q;
   logic [DATA_W-1:0]   h_data_q, t_data_q;
   logic [ADDR_W-1:0]   h_idx_q, t_idx_q;
   logic                h_last_q, t_last_q;
   logic                busy_q, done_q, overrun_q;

   logic                pop;
   logic                issue;
   logic [2:0]          occ_d;
   logic                push_last_d;

`ifdef DFT_READER_BITREV_EN
   localparam int KW = $clog2(ADDR_W);
   logic [KW-1:0] k_q;

   function automatic logic [KW-1:0] msb_idx(input logic [ADDR_W-1:0] v);
      msb_idx = '0;
      for (int i = 0; i < ADDR_W; i++)
         if (v[i]) msb_idx = KW'(i);
   endfunction

   always_comb begin
      ram_addr = rd_idx_q;
      for (int i = 0; i < ADDR_W; i++)
         if (i < int'(k_q)) ram_addr[i] = rd_idx_q[int'(k_q) - 1 - i];
   end
`else
   assign ram_addr = rd_idx_q;
`endif

   // Occupancy counts the beat leaving this cycle so a full pipeline still sustains 1 beat/cycle.
   always_comb begin
      pop         = ce & (cnt_q != 2'd0) & m_ready;
      occ_d       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue       = ce & (state_q == STREAM) & (rd_idx_q < n_q) & (occ_d < 3'd2);
      push_last_d = (infl_idx_q == (n_q - ONE));
   end

   assign ram_rd_en = issue;
   assign m_valid   = (cnt_q != 2'd0);
   assign m_data    = h_data_q;
   assign m_index   = h_idx_q;
   assign m_last    = h_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = overrun_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         rd_idx_q   <= '0;
         inflight_q <= 1'b0;
         infl_idx_q <= '0;
         cnt_q      <= 2'd0;
         h_data_q   <= '0;
         t_data_q   <= '0;
         h_idx_q    <= '0;
         t_idx_q    <= '0;
         h_last_q   <= 1'b0;
         t_last_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef DFT_READER_BITREV_EN
         k_q        <= '0;
`endif
      end else if (ce) begin
         overrun_q  <= calc_end && (state_q != IDLE);
         done_q     <= 1'b0;
         inflight_q <= issue;
         if (issue) begin
            rd_idx_q   <= rd_idx_q + ONE;
            infl_idx_q <= rd_idx_q;
         end

         // Head always holds the oldest beat; the tail only fills when head is occupied.
         case ({inflight_q, pop})
            2'b10: begin
               if (cnt_q == 2'd0) begin
                  h_data_q <= ram_rd_data;
                  h_idx_q  <= infl_idx_q;
                  h_last_q <= push_last_d;
               end else begin
                  t_data_q <= ram_rd_data;
                  t_idx_q  <= infl_idx_q;
                  t_last_q <= push_last_d;
               end
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               h_data_q <= t_data_q;
               h_idx_q  <= t_idx_q;
               h_last_q <= t_last_q;
               cnt_q    <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  h_data_q <= ram_rd_data;
                  h_idx_q  <= infl_idx_q;
                  h_last_q <= push_last_d;
               end else begin
                  h_data_q <= t_data_q;
                  h_idx_q  <= t_idx_q;
                  h_last_q <= t_last_q;
                  t_data_q <= ram_rd_data;
                  t_idx_q  <= infl_idx_q;
                  t_last_q <= push_last_d;
               end
            end
            default: ;
         endcase

         case (state_q)
            IDLE: begin
               if (calc_end) begin
                  n_q      <= sample_num;
                  rd_idx_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= STREAM;
`ifdef DFT_READER_BITREV_EN
                  k_q      <= msb_idx(sample_num);
`endif
               end
            end
            // N==0 spends its single busy cycle here with no reads issued, then completes.
            STREAM: begin
               if ((n_q == '0) || (pop && h_last_q)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE_ST;
               end
            end
            DONE_ST: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
